// File: rtl/eth_udp_pkg.sv
// rtl/eth_udp_pkg.sv - shared UDP receive-path constants, FSM encoding and helpers
package eth_udp_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RECV  = ST_RECV,
    S_FLUSH = ST_FLUSH,
    S_DONE  = ST_DONE,
    S_WAIT  = ST_WAIT
  } rx_state_e;

  localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd1472;
  localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
  localparam int          WORD_BYTES      = 4;

  // Lanes are filled from [31:24] downward, so n bytes occupy the top n keep bits.
  function automatic logic [3:0] keep_from_cnt(input logic [1:0] n);
    case (n)
      2'd1:    keep_from_cnt = 4'b1000;
      2'd2:    keep_from_cnt = 4'b1100;
      2'd3:    keep_from_cnt = 4'b1110;
      default: keep_from_cnt = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/udp_rx_word_packer.sv
// rtl/udp_rx_word_packer.sv - packs UDP payload bytes into big-endian 32-bit FIFO words
module udp_rx_word_packer
  import eth_udp_pkg::*;
#(
  parameter logic [15:0] MAX_LEN     = UDP_MAX_PAYLOAD,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic                   i_gmii_rx_clk,
  input  logic                   i_sys_rstn,
  input  logic                   i_rec_dvalid,
  input  logic [7:0]             i_rec_data,
  input  logic [15:0]            i_rec_data_num,
  input  logic                   i_udp_rec_done,
  input  logic                   i_wfifo_full,
  output logic                   o_wfifo_wr_en,
  output logic [31:0]            o_wfifo_wr_data,
  output logic [3:0]             o_wfifo_wr_keep,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_len,
  output logic                   o_frame_err,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = 1;

  rx_state_e              state_q, state_d;
  logic                   done_d_q;
  logic [15:0]            exp_len_q, exp_len_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]            lanes_q, lanes_d;
  logic                   ovf_q, ovf_d;
  logic                   ovr_q, ovr_d;
  logic                   pend_q, pend_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic [3:0]             keep_q, keep_d;
  logic                   frame_done_q, frame_done_d;
  logic [15:0]            frame_len_q, frame_len_d;
  logic                   frame_err_q, frame_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   done_rise;
  logic [31:0]            next_word;
  logic                   go_done;
  logic                   done_err;

  assign done_rise = i_udp_rec_done & ~done_d_q;

  always_comb begin
    next_word = lanes_q;
    next_word[{~byte_cnt_q[1:0], 3'b000} +: 8] = i_rec_data;
  end

  always_comb begin
    state_d      = state_q;
    exp_len_d    = exp_len_q;
    byte_cnt_d   = byte_cnt_q;
    lanes_d      = lanes_q;
    ovf_d        = ovf_q | (pend_q & i_wfifo_full);
    ovr_d        = ovr_q;
    pend_d       = 1'b0;
    wr_data_d    = wr_data_q;
    keep_d       = keep_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_err_d  = frame_err_q;
    frame_cnt_d  = frame_cnt_q;
    go_done      = 1'b0;
    done_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rec_dvalid && !i_udp_rec_done) begin
          exp_len_d  = i_rec_data_num;
          lanes_d    = {i_rec_data, 24'h0};
          byte_cnt_d = 16'd1;
          state_d    = S_RECV;
        end else if (done_rise) begin
          byte_cnt_d = 16'd0;
          go_done    = 1'b1;
          done_err   = (i_rec_data_num != 16'd0);
        end
      end

      S_RECV: begin
        if (i_rec_dvalid) begin
          if (byte_cnt_q >= MAX_LEN) begin
            ovr_d = 1'b1;
          end else begin
            if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_q[1:0] == 2'b11) begin
              pend_d    = 1'b1;
              wr_data_d = next_word;
              keep_d    = 4'b1111;
              lanes_d   = 32'h0;
            end else begin
              lanes_d = next_word;
            end
          end
        end
        // A word completed by the last byte also takes the FLUSH slot so a
        // full FIFO in its write cycle is still reflected in the summary.
        if (done_rise) begin
          if (byte_cnt_d[1:0] != 2'b00) begin
            pend_d    = 1'b1;
            wr_data_d = lanes_d;
            keep_d    = keep_from_cnt(byte_cnt_d[1:0]);
            lanes_d   = 32'h0;
          end
          if (pend_d) begin
            state_d = S_FLUSH;
          end else begin
            go_done  = 1'b1;
            done_err = ovf_d | ovr_d | (byte_cnt_d != exp_len_q);
          end
        end
      end

      S_FLUSH: begin
        go_done  = 1'b1;
        done_err = ovf_d | ovr_q | (byte_cnt_q != exp_len_q);
      end

      S_DONE: begin
        byte_cnt_d = 16'd0;
        lanes_d    = 32'h0;
        ovf_d      = 1'b0;
        ovr_d      = 1'b0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (!i_udp_rec_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_done) begin
      frame_done_d = 1'b1;
      frame_len_d  = byte_cnt_d;
      frame_err_d  = done_err;
      if (!done_err) frame_cnt_d = frame_cnt_q + CNT_ONE;
      state_d      = S_DONE;
    end
  end

  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state_q      <= S_IDLE;
      done_d_q     <= 1'b0;
      exp_len_q    <= 16'd0;
      byte_cnt_q   <= 16'd0;
      lanes_q      <= 32'h0;
      ovf_q        <= 1'b0;
      ovr_q        <= 1'b0;
      pend_q       <= 1'b0;
      wr_data_q    <= 32'h0;
      keep_q       <= 4'h0;
      frame_done_q <= 1'b0;
      frame_len_q  <= 16'd0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      done_d_q     <= i_udp_rec_done;
      exp_len_q    <= exp_len_d;
      byte_cnt_q   <= byte_cnt_d;
      lanes_q      <= lanes_d;
      ovf_q        <= ovf_d;
      ovr_q        <= ovr_d;
      pend_q       <= pend_d;
      wr_data_q    <= wr_data_d;
      keep_q       <= keep_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Write strobe is gated by the FIFO level in the write cycle itself.
  assign o_wfifo_wr_en   = pend_q & ~i_wfifo_full;
  assign o_wfifo_wr_data = wr_data_q;
  assign o_wfifo_wr_keep = keep_q;
  assign o_frame_done    = frame_done_q;
  assign o_frame_len     = frame_len_q;
  assign o_frame_err     = frame_err_q;
  assign o_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_udp_rx_word_packer.sv
// tb/tb_udp_rx_word_packer.sv - directed self-checking bench for udp_rx_word_packer
module tb_udp_rx_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dvalid;
  logic [7:0]  data;
  logic [15:0] data_num;
  logic        rec_done;
  logic        full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_keep;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wq_data[$];
  logic [3:0]  wq_keep[$];
  int          wq_stamp[$];
  int          fd_n;
  logic [15:0] fd_len;
  logic        fd_err;
  logic [15:0] fd_cnt;
  int          fd_stamp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_rx_word_packer dut (
    .i_gmii_rx_clk   (clk),
    .i_sys_rstn      (rst_n),
    .i_rec_dvalid    (dvalid),
    .i_rec_data      (data),
    .i_rec_data_num  (data_num),
    .i_udp_rec_done  (rec_done),
    .i_wfifo_full    (full),
    .o_wfifo_wr_en   (wr_en),
    .o_wfifo_wr_data (wr_data),
    .o_wfifo_wr_keep (wr_keep),
    .o_frame_done    (frame_done),
    .o_frame_len     (frame_len),
    .o_frame_err     (frame_err),
    .o_frame_cnt     (frame_cnt)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wq_data.push_back(wr_data);
        wq_keep.push_back(wr_keep);
        wq_stamp.push_back(cyc);
      end
      if (frame_done) begin
        fd_n++;
        fd_len   = frame_len;
        fd_err   = frame_err;
        fd_cnt   = frame_cnt;
        fd_stamp = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_data.delete();
    wq_keep.delete();
    wq_stamp.delete();
    fd_n = 0;
  endtask

  task automatic send(input logic [7:0] b);
    dvalid = 1'b1;
    data   = b;
    tick();
    dvalid = 1'b0;
  endtask

  task automatic pulse_done();
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (fd_n == 0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fd_n == 0) begin
      failures++;
      $display("FAIL %s_timeout: no frame_done within %0d cycles", name, n);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wr_en, wr_data, wr_keep, frame_done} !== 38'h0) begin
      failures++;
      $display("FAIL reset_wr: got en=%b data=%h keep=%h done=%b expected all 0", wr_en, wr_data, wr_keep, frame_done);
    end
    checks++;
    if ({frame_len, frame_err, frame_cnt} !== 33'h0) begin
      failures++;
      $display("FAIL reset_frame: got len=%0d err=%b cnt=%0d expected 0", frame_len, frame_err, frame_cnt);
    end
  endtask

  task automatic test_aligned();
    int t4, td;
    clear_log();
    data_num = 16'd8;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) t4 = cyc;
      send(8'(i + 1));
    end
    tick();
    td = cyc;
    pulse_done();
    wait_done("aligned");
    checks++;
    if (wq_data.size() !== 2) begin failures++; $display("FAIL aligned_nwr: got %0d expected 2", wq_data.size()); end
    checks++;
    if ({wq_data[0], wq_keep[0]} !== {32'h01020304, 4'hF}) begin failures++; $display("FAIL aligned_w0: got %h/%h expected 01020304/f", wq_data[0], wq_keep[0]); end
    checks++;
    if ({wq_data[1], wq_keep[1]} !== {32'h05060708, 4'hF}) begin failures++; $display("FAIL aligned_w1: got %h/%h expected 05060708/f", wq_data[1], wq_keep[1]); end
    checks++;
    if (wq_stamp[0] !== t4 + 1) begin failures++; $display("FAIL aligned_wr_lat: got cycle %0d expected %0d", wq_stamp[0], t4 + 1); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd8, 1'b0, 16'd1}) begin failures++; $display("FAIL aligned_sum: got len=%0d err=%b cnt=%0d expected 8/0/1", fd_len, fd_err, fd_cnt); end
    checks++;
    if (fd_stamp !== td + 1) begin failures++; $display("FAIL aligned_done_lat: got cycle %0d expected %0d", fd_stamp, td + 1); end
  endtask

  task automatic test_flush();
    int td;
    clear_log();
    data_num = 16'd5;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    dvalid   = 1'b1;
    data     = 8'hEE;
    rec_done = 1'b1;
    td = cyc;
    tick();
    dvalid = 1'b0;
    tick();
    rec_done = 1'b0;
    wait_done("flush");
    checks++;
    if (wq_data.size() !== 2) begin failures++; $display("FAIL flush_nwr: got %0d expected 2", wq_data.size()); end
    checks++;
    if ({wq_data[0], wq_keep[0]} !== {32'hAABBCCDD, 4'hF}) begin failures++; $display("FAIL flush_w0: got %h/%h expected aabbccdd/f", wq_data[0], wq_keep[0]); end
    checks++;
    if ({wq_data[1], wq_keep[1]} !== {32'hEE000000, 4'h8}) begin failures++; $display("FAIL flush_w1: got %h/%h expected ee000000/8", wq_data[1], wq_keep[1]); end
    checks++;
    if (wq_stamp[1] !== td + 1) begin failures++; $display("FAIL flush_wr_lat: got cycle %0d expected %0d", wq_stamp[1], td + 1); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd5, 1'b0, 16'd2}) begin failures++; $display("FAIL flush_sum: got len=%0d err=%b cnt=%0d expected 5/0/2", fd_len, fd_err, fd_cnt); end
    checks++;
    if (fd_stamp !== td + 2) begin failures++; $display("FAIL flush_done_lat: got cycle %0d expected %0d", fd_stamp, td + 2); end
  endtask

  task automatic test_short();
    clear_log();
    data_num = 16'd6;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
    tick();
    pulse_done();
    wait_done("short");
    checks++;
    if (wq_data.size() !== 1 || wq_data[0] !== 32'h10111213) begin failures++; $display("FAIL short_wr: got n=%0d w0=%h expected 1/10111213", wq_data.size(), wq_data[0]); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd4, 1'b1, 16'd2}) begin failures++; $display("FAIL short_sum: got len=%0d err=%b cnt=%0d expected 4/1/2", fd_len, fd_err, fd_cnt); end
  endtask

  task automatic test_fifo_full();
    clear_log();
    data_num = 16'd12;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) full = 1'b1;
      if (i == 9) full = 1'b0;
      send(8'(8'h21 + i));
    end
    tick();
    pulse_done();
    wait_done("full");
    checks++;
    if (wq_data.size() !== 2) begin failures++; $display("FAIL full_nwr: got %0d expected 2", wq_data.size()); end
    checks++;
    if (wq_data[0] !== 32'h21222324 || wq_data[1] !== 32'h292A2B2C) begin failures++; $display("FAIL full_words: got %h %h expected 21222324 292a2b2c", wq_data[0], wq_data[1]); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd12, 1'b1, 16'd2}) begin failures++; $display("FAIL full_sum: got len=%0d err=%b cnt=%0d expected 12/1/2", fd_len, fd_err, fd_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    data_num = 16'd4;
    send(8'h55); send(8'h66); send(8'h77);
    dvalid   = 1'b1;
    data     = 8'h88;
    rec_done = 1'b1;
    repeat (3) tick();
    dvalid   = 1'b0;
    rec_done = 1'b0;
    wait_done("held");
    checks++;
    if (wq_data.size() !== 1 || {wq_data[0], wq_keep[0]} !== {32'h55667788, 4'hF}) begin failures++; $display("FAIL held_wr: got n=%0d w0=%h/%h expected 1/55667788/f", wq_data.size(), wq_data[0], wq_keep[0]); end
    checks++;
    if ({fd_n, fd_len, fd_err, fd_cnt} !== {32'd1, 16'd4, 1'b0, 16'd3}) begin failures++; $display("FAIL held_sum: got n=%0d len=%0d err=%b cnt=%0d expected 1/4/0/3", fd_n, fd_len, fd_err, fd_cnt); end
    clear_log();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick();
    pulse_done();
    wait_done("b2b");
    checks++;
    if (wq_data.size() !== 1 || {wq_data[0], wq_keep[0]} !== {32'h11223344, 4'hF}) begin failures++; $display("FAIL b2b_wr: got n=%0d w0=%h/%h expected 1/11223344/f", wq_data.size(), wq_data[0], wq_keep[0]); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd4, 1'b0, 16'd4}) begin failures++; $display("FAIL b2b_sum: got len=%0d err=%b cnt=%0d expected 4/0/4", fd_len, fd_err, fd_cnt); end
  endtask

  task automatic test_empty();
    clear_log();
    data_num = 16'd0;
    pulse_done();
    wait_done("empty");
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd0, 1'b0, 16'd5} || wq_data.size() !== 0) begin failures++; $display("FAIL empty_sum: got len=%0d err=%b cnt=%0d nwr=%0d expected 0/0/5/0", fd_len, fd_err, fd_cnt, wq_data.size()); end
  endtask

  task automatic test_overrun();
    clear_log();
    data_num = 16'd1474;
    for (int i = 0; i < 1474; i++) send(8'(i));
    tick();
    pulse_done();
    wait_done("ovr");
    checks++;
    if (wq_data.size() !== 368) begin failures++; $display("FAIL ovr_nwr: got %0d expected 368", wq_data.size()); end
    checks++;
    if (wq_data[wq_data.size() - 1] !== 32'hBCBDBEBF) begin failures++; $display("FAIL ovr_last: got %h expected bcbdbebf", wq_data[wq_data.size() - 1]); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd1472, 1'b1, 16'd5}) begin failures++; $display("FAIL ovr_sum: got len=%0d err=%b cnt=%0d expected 1472/1/5", fd_len, fd_err, fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    data_num = 16'd4;
    send(8'hE1); send(8'hE2); send(8'hE3);
    rst_n = 1'b0;
    tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (wq_data.size() !== 0 || fd_n !== 0) begin failures++; $display("FAIL rstmid_quiet: got nwr=%0d ndone=%0d expected 0/0", wq_data.size(), fd_n); end
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    tick();
    pulse_done();
    wait_done("rstmid");
    checks++;
    if (wq_data.size() !== 1 || {wq_data[0], wq_keep[0]} !== {32'hC1C2C3C4, 4'hF}) begin failures++; $display("FAIL rstmid_wr: got n=%0d w0=%h/%h expected 1/c1c2c3c4/f", wq_data.size(), wq_data[0], wq_keep[0]); end
    checks++;
    if ({fd_len, fd_err, fd_cnt} !== {16'd4, 1'b0, 16'd1}) begin failures++; $display("FAIL rstmid_sum: got len=%0d err=%b cnt=%0d expected 4/0/1", fd_len, fd_err, fd_cnt); end
  endtask

  initial begin
    rst_n    = 1'b0;
    dvalid   = 1'b0;
    data     = 8'h0;
    data_num = 16'd0;
    rec_done = 1'b0;
    full     = 1'b0;
    fd_n     = 0;
    repeat (3) tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    test_aligned();
    test_flush();
    test_short();
    test_fifo_full();
    test_back_to_back();
    test_empty();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
